// File: rtl/flow_director_arb.sv
// flow_director_arb
//   Round-robin scheduler that shares the single metadata input of flow_director
//   among NUM_IN requesters. Each beat it grants one requester. A requester that
//   wins keeps the grant for up to QUANTUM consecutive beats before the pointer
//   moves on. The chosen beat is registered onto out_meta_*, and the module counts
//   the beats delivered downstream.
//   metadata_t is carried as an opaque META_W-bit vector.
//
// Ports
//   clk_i             single clock
//   rst_ni            asynchronous active-low reset
//   in_meta_data_i    requester i metadata, index i
//   in_meta_valid_i   requester i has a beat
//   in_meta_ready_o   beat of requester i accepted this cycle (one-hot or zero)
//   out_meta_data_o   registered metadata to flow_director
//   out_meta_valid_o  registered valid to flow_director
//   out_meta_ready_i  ready from flow_director
//   fwd_cnt_o         beats delivered downstream (valid & ready), wraps
//
// State    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no burst owner; the round-robin search from rr_ptr picks a winner
// ST_BURST | owner_q holds the grant while it stays valid and is under QUANTUM

module flow_director_arb #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned QUANTUM = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned META_W  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_IN-1:0][META_W-1:0] in_meta_data_i,
  input  logic [NUM_IN-1:0]             in_meta_valid_i,
  output logic [NUM_IN-1:0]             in_meta_ready_o,
  output logic [META_W-1:0]             out_meta_data_o,
  output logic                          out_meta_valid_o,
  input  logic                          out_meta_ready_i,
  output logic [CNT_W-1:0]              fwd_cnt_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_IN);
  localparam int unsigned BCNT_W = $clog2(QUANTUM + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IN - 1);
  localparam logic [BCNT_W-1:0] QUANTUM_C = BCNT_W'(QUANTUM);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [META_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;

  logic                         load_en;
  logic                         pick_found;
  logic [IDX_W-1:0]             pick_idx;
  logic [NUM_IN-1:0][IDX_W-1:0] cand_idx;
  logic                         grant_vld;
  logic [IDX_W-1:0]             grant_idx;
  logic [NUM_IN-1:0]            grant_oh;
  logic [BCNT_W-1:0]            burst_inc;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // The output register can take a new beat when empty or draining this cycle.
  assign load_en = !out_valid_q || out_meta_ready_i;

  // Round-robin search: candidate k is (rr_ptr + k) mod NUM_IN, first valid wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_idx[k] = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NUM_IN);
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (!pick_found && in_meta_valid_i[cand_idx[k]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign burst_inc = burst_cnt_q + BCNT_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    grant_vld   = 1'b0;
    grant_idx   = owner_q;

    unique case (state_q)
      ST_IDLE: begin
        grant_vld = pick_found;
        grant_idx = pick_idx;
        if (load_en && pick_found) begin
          owner_d     = pick_idx;
          burst_cnt_d = BCNT_W'(1);
          if (QUANTUM > 1) begin
            state_d = ST_BURST;
          end else begin
            rr_ptr_d = next_idx(pick_idx);
          end
        end
      end

      ST_BURST: begin
        // Grant stays with the owner; nothing moves unless the register can load,
        // so the owner may drop valid while stalled without losing its burst.
        grant_vld = in_meta_valid_i[owner_q];
        if (load_en) begin
          if (in_meta_valid_i[owner_q]) begin
            burst_cnt_d = burst_inc;
            if (burst_inc == QUANTUM_C) begin
              rr_ptr_d = next_idx(owner_q);
              state_d  = ST_IDLE;
            end
          end else begin
            // Owner went idle: give up the burst, costing one bubble cycle.
            rr_ptr_d = next_idx(owner_q);
            state_d  = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant_oh[i] = grant_vld && (grant_idx == IDX_W'(i));
    end
  end

  // No handshake completes while reset is held.
  assign in_meta_ready_o = grant_oh & {NUM_IN{load_en & rst_ni}};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    fwd_cnt_d   = fwd_cnt_q + CNT_W'(out_valid_q & out_meta_ready_i);
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = in_meta_data_i[grant_idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign out_meta_valid_o = out_valid_q;
  assign out_meta_data_o  = out_data_q;
  assign fwd_cnt_o        = fwd_cnt_q;

endmodule

// File: tb/tb_flow_director_arb.sv
module tb_flow_director_arb;

  localparam int NUM_IN  = 4;
  localparam int QUANTUM = 4;
  localparam int CNT_W   = 32;
  localparam int META_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n;
  logic [NUM_IN-1:0][META_W-1:0] in_data;
  logic [NUM_IN-1:0]             in_vld;
  logic [NUM_IN-1:0]             in_rdy;
  logic [META_W-1:0]             out_data;
  logic                          out_vld;
  logic                          out_rdy;
  logic [CNT_W-1:0]              fwd;

  int vec_cnt = 0;
  int err_cnt = 0;

  flow_director_arb #(
    .NUM_IN (NUM_IN),
    .QUANTUM(QUANTUM),
    .CNT_W  (CNT_W),
    .META_W (META_W)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_meta_data_i  (in_data),
    .in_meta_valid_i (in_vld),
    .in_meta_ready_o (in_rdy),
    .out_meta_data_o (out_data),
    .out_meta_valid_o(out_vld),
    .out_meta_ready_i(out_rdy),
    .fwd_cnt_o       (fwd)
  );

  // Reference model: owner < 0 means nobody holds a burst.
  int                m_owner;
  int                m_beats;
  int                m_ptr;
  logic              m_ov;
  logic [META_W-1:0] m_od;
  logic [CNT_W-1:0]  m_fwd;

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_fwd   = '0;
  endtask

  function automatic int model_pick();
    if (m_owner >= 0) return in_vld[m_owner] ? m_owner : -1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_vld[(m_ptr + k) % NUM_IN]) return (m_ptr + k) % NUM_IN;
    end
    return -1;
  endfunction

  function automatic logic [NUM_IN-1:0] model_rdy();
    int g;
    g = model_pick();
    if ((m_ov && !out_rdy) || g < 0) return '0;
    return NUM_IN'(1) << g;
  endfunction

  task automatic model_update();
    int  g;
    bit  load;
    load = !m_ov || out_rdy;
    g    = model_pick();
    if (m_ov && out_rdy) m_fwd = m_fwd + 1;
    if (load) begin
      if (g >= 0) begin
        m_ov = 1'b1;
        m_od = in_data[g];
        if (m_owner < 0) begin
          m_owner = g;
          m_beats = 1;
        end else begin
          m_beats = m_beats + 1;
        end
        if (m_beats == QUANTUM) begin
          m_ptr   = (g + 1) % NUM_IN;
          m_owner = -1;
        end
      end else begin
        m_ov = 1'b0;
        if (m_owner >= 0) begin
          m_ptr   = (m_owner + 1) % NUM_IN;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NUM_IN; i++) in_data[i] = $urandom;
  endtask

  task automatic apply_reset();
    in_vld  = '0;
    out_rdy = 1'b1;
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_vld  = '0;
    out_rdy = 1'b1;
    rst_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      randomize_data();
      #1;
      vec_cnt++;
      if (out_vld !== 1'b0 || in_rdy !== '0 || fwd !== '0 || out_data !== '0) begin
        err_cnt++;
        $display("FAIL reset_idle cycle %0d: got vld=%b rdy=%b fwd=%0d data=%h, want 0 0 0 0",
                 c, out_vld, in_rdy, fwd, out_data);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_IN-1:0] exp;
    apply_reset();
    in_vld  = '1;
    out_rdy = 1'b1;
    for (int c = 0; c < 32; c++) begin
      randomize_data();
      #1;
      exp = NUM_IN'(1) << ((c / QUANTUM) % NUM_IN);
      vec_cnt++;
      if (in_rdy !== exp) begin
        err_cnt++;
        $display("FAIL rr_grant cycle %0d: got %b want %b", c, in_rdy, exp);
      end
      vec_cnt++;
      if (out_vld !== m_ov || out_data !== m_od) begin
        err_cnt++;
        $display("FAIL rr_out cycle %0d: got %b/%h want %b/%h", c, out_vld, out_data, m_ov, m_od);
      end
      tick();
    end
    #1;
    vec_cnt++;
    if (fwd !== 32'd31) begin
      err_cnt++;
      $display("FAIL rr_fwd_cnt: got %0d want 31", fwd);
    end
  endtask

  task automatic test_bubble_wrap();
    logic [NUM_IN-1:0] vld_tab [6];
    logic [NUM_IN-1:0] rdy_tab [6];
    vld_tab = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010};
    rdy_tab = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010};
    apply_reset();
    out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_vld = vld_tab[c];
      randomize_data();
      #1;
      vec_cnt++;
      if (in_rdy !== rdy_tab[c]) begin
        err_cnt++;
        $display("FAIL bubble_grant cycle %0d: got %b want %b", c, in_rdy, rdy_tab[c]);
      end
      vec_cnt++;
      if (out_vld !== (c != 0 && c != 4) || out_data !== m_od) begin
        err_cnt++;
        $display("FAIL bubble_out cycle %0d: got %b/%h want %b/%h",
                 c, out_vld, out_data, (c != 0 && c != 4), m_od);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [META_W-1:0] held;
    apply_reset();
    in_vld  = 4'b0001;
    out_rdy = 1'b1;
    randomize_data();
    held = in_data[0];
    #1;
    vec_cnt++;
    if (in_rdy !== 4'b0001) begin
      err_cnt++;
      $display("FAIL stall_first_grant: got %b want 0001", in_rdy);
    end
    tick();
    for (int s = 0; s < 5; s++) begin
      out_rdy = 1'b0;
      in_vld  = (s == 1 || s == 2) ? 4'b0000 : 4'b0001;
      randomize_data();
      #1;
      vec_cnt++;
      if (out_vld !== 1'b1 || out_data !== held || in_rdy !== '0 || fwd !== '0) begin
        err_cnt++;
        $display("FAIL stall_hold cycle %0d: got vld=%b data=%h rdy=%b fwd=%0d want 1 %h 0000 0",
                 s, out_vld, out_data, in_rdy, fwd, held);
      end
      tick();
    end
    out_rdy = 1'b1;
    in_vld  = 4'b0001;
    randomize_data();
    #1;
    vec_cnt++;
    if (in_rdy !== 4'b0001) begin
      err_cnt++;
      $display("FAIL stall_resume_grant: got %b want 0001", in_rdy);
    end
    tick();
    #1;
    vec_cnt++;
    if (fwd !== 32'd1 || out_data !== m_od) begin
      err_cnt++;
      $display("FAIL stall_resume_out: got fwd=%0d data=%h want 1 %h", fwd, out_data, m_od);
    end
  endtask

  task automatic test_back_to_back();
    logic [META_W-1:0] prev;
    apply_reset();
    in_vld  = 4'b0001;
    out_rdy = 1'b1;
    prev    = '0;
    for (int c = 0; c < 12; c++) begin
      randomize_data();
      #1;
      vec_cnt++;
      if (in_rdy !== 4'b0001) begin
        err_cnt++;
        $display("FAIL b2b_grant cycle %0d: got %b want 0001", c, in_rdy);
      end
      if (c > 0) begin
        vec_cnt++;
        if (out_vld !== 1'b1 || out_data !== prev) begin
          err_cnt++;
          $display("FAIL b2b_out cycle %0d: got %b/%h want 1/%h", c, out_vld, out_data, prev);
        end
      end
      prev = in_data[0];
      tick();
    end
    #1;
    vec_cnt++;
    if (fwd !== 32'd11) begin
      err_cnt++;
      $display("FAIL b2b_fwd_cnt: got %0d want 11", fwd);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [META_W-1:0] exp_data;
    apply_reset();
    out_rdy = 1'b1;
    in_vld  = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      randomize_data();
      #1;
      tick();
    end
    #1;
    vec_cnt++;
    if (fwd !== 32'd1 || out_vld !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_pre: got fwd=%0d vld=%b want 1 1", fwd, out_vld);
    end
    in_vld = 4'b0101;
    randomize_data();
    rst_n = 1'b0;
    model_reset();
    #1;
    vec_cnt++;
    if (out_vld !== 1'b0 || out_data !== '0 || in_rdy !== '0 || fwd !== '0) begin
      err_cnt++;
      $display("FAIL midrst_zero: got vld=%b data=%h rdy=%b fwd=%0d want all 0",
               out_vld, out_data, in_rdy, fwd);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_data = in_data[0];
    #1;
    vec_cnt++;
    if (in_rdy !== 4'b0001) begin
      err_cnt++;
      $display("FAIL midrst_first_grant: got %b want 0001", in_rdy);
    end
    tick();
    #1;
    vec_cnt++;
    if (out_vld !== 1'b1 || out_data !== exp_data) begin
      err_cnt++;
      $display("FAIL midrst_first_beat: got %b/%h want 1/%h", out_vld, out_data, exp_data);
    end
  endtask

  task automatic test_random();
    logic [NUM_IN-1:0] exp;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      randomize_data();
      for (int i = 0; i < NUM_IN; i++) in_vld[i] = ($urandom_range(0, 9) < 6);
      out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      exp = model_rdy();
      vec_cnt++;
      if (in_rdy !== exp) begin
        err_cnt++;
        $display("FAIL rand_ready cycle %0d: got %b want %b", c, in_rdy, exp);
      end
      vec_cnt++;
      if (out_vld !== m_ov || out_data !== m_od || fwd !== m_fwd) begin
        err_cnt++;
        $display("FAIL rand_out cycle %0d: got %b/%h/%0d want %b/%h/%0d",
                 c, out_vld, out_data, fwd, m_ov, m_od, m_fwd);
      end
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    in_vld  = '0;
    out_rdy = 1'b0;
    in_data = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_bubble_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
